// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, opcodes, FSM state type and helpers for muldiv_unit
package muldiv_pkg;
  localparam int XLEN = 64;
  localparam int CNT_W = 6;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the register file and muldiv_unit
// master drives the request (valid, opcode, operands, destination, flush);
// slave returns ready, the one-cycle result pulse, rd_addr/rd_data and busy.
interface muldiv_if;
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 funct3;
  logic                       op_word;
  logic [muldiv_pkg::XLEN-1:0] rs1_data;
  logic [muldiv_pkg::XLEN-1:0] rs2_data;
  logic [4:0]                 rd_addr_in;
  logic                       flush;
  logic                       out_valid;
  logic [4:0]                 rd_addr;
  logic [muldiv_pkg::XLEN-1:0] rd_data;
  logic                       busy;
  modport master (
    output in_valid, funct3, op_word, rs1_data, rs2_data, rd_addr_in, flush,
    input  in_ready, out_valid, rd_addr, rd_data, busy
  );
  modport slave (
    input  in_valid, funct3, op_word, rs1_data, rs2_data, rd_addr_in, flush,
    output in_ready, out_valid, rd_addr, rd_data, busy
  );
endinterface

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: conditional two's-complement negate (absolute value when neg = sign bit)
// a: value in, neg: negate when 1, y: result.
module muldiv_sign_adj
  import muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide, one bit per cycle
// Ports: clk, rst_n (async active-low), m (muldiv_if.slave: request in, result pulse out).
// Optional: MULDIV_WORD_OPS_EN enables the RV64 *W ops selected by op_word.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  m
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rd_data_q, rd_data_d;
  logic an_q, an_d, bn_q, bn_d, word_q, word_d;
  logic [2:0] op_q, op_d;
  logic [4:0] dst_q, dst_d, rd_addr_q, rd_addr_d;
  logic word;
`ifdef MULDIV_WORD_OPS_EN
  assign word = m.op_word;
`else
  assign word = 1'b0 & m.op_word;
`endif
  // operand conditioning: extend (word ops), then take magnitudes
  logic a_sign, b_sign, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  assign a_sign = m.funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign b_sign = m.funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  assign a_ext = word ? {{32{a_sign & m.rs1_data[31]}}, m.rs1_data[31:0]} : m.rs1_data;
  assign b_ext = word ? {{32{b_sign & m.rs2_data[31]}}, m.rs2_data[31:0]} : m.rs2_data;
  assign a_neg = a_sign & a_ext[XLEN-1];
  assign b_neg = b_sign & b_ext[XLEN-1];
  muldiv_sign_adj #(.W(XLEN)) u_abs_a (.a(a_ext), .neg(a_neg), .y(a_mag));
  muldiv_sign_adj #(.W(XLEN)) u_abs_b (.a(b_ext), .neg(b_neg), .y(b_mag));
  // shift-add step: acc = {partial high, remaining multiplier bits}
  logic [XLEN:0] mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_src, prod_fix;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  // 32 word iterations leave the product 32 bits above its final position
  assign prod_src = word_q ? {32'b0, mul_next[2*XLEN-1:32]} : mul_next;
  muldiv_sign_adj #(.W(2*XLEN)) u_fix_p (.a(prod_src), .neg(an_q ^ bn_q), .y(prod_fix));
  logic [XLEN-1:0] mul_res;
  assign mul_res = word_q ? (op_q == F3_MUL ? sext32(prod_fix[31:0]) : '0)
                          : (op_q == F3_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
  // restoring step: acc = {remainder, dividend bits / quotient bits}
  logic [XLEN:0] div_sh, div_tr;
  logic div_ok;
  logic [2*XLEN-1:0] div_next;
  assign div_sh = acc_q[2*XLEN-1:XLEN-1];
  assign div_tr = div_sh - {1'b0, b_q};
  assign div_ok = !div_tr[XLEN];
  assign div_next = {div_ok ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ok};
  // 64-bit divide by zero / signed overflow finish without iterating; word ops always iterate
  logic b_zero, ovf, fast, last;
  assign b_zero = b_q == '0;
  assign ovf = an_q & bn_q & (b_q == XLEN'(1)) & (a_q == {1'b1, {(XLEN-1){1'b0}}});
  assign fast = !word_q && cnt_q == '0 && (b_zero || ovf);
  assign last = cnt_q == (word_q ? CNT_W'(31) : CNT_W'(63));
  logic [XLEN-1:0] quo_src, rem_src, quo_fix, rem_fix, div_sel, div_res;
  assign quo_src = fast ? (b_zero ? '1 : a_q) : div_next[XLEN-1:0];
  assign rem_src = fast ? (b_zero ? a_q : '0) : div_next[2*XLEN-1:XLEN];
  muldiv_sign_adj #(.W(XLEN)) u_fix_q (.a(quo_src), .neg((an_q ^ bn_q) & !b_zero), .y(quo_fix));
  muldiv_sign_adj #(.W(XLEN)) u_fix_r (.a(rem_src), .neg(an_q), .y(rem_fix));
  assign div_sel = op_q[1] ? rem_fix : quo_fix;
  assign div_res = word_q ? sext32(div_sel[31:0]) : div_sel;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    an_d = an_q;
    bn_d = bn_q;
    op_d = op_q;
    word_d = word_q;
    dst_d = dst_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: if (m.in_valid && !m.flush) begin
        state_d = m.funct3[2] ? DIV : MUL;
        cnt_d = '0;
        acc_d = {{XLEN{1'b0}}, m.funct3[2] ? (word ? {a_mag[31:0], 32'b0} : a_mag) : b_mag};
        a_d = a_mag;
        b_d = b_mag;
        an_d = a_neg;
        bn_d = b_neg;
        op_d = m.funct3;
        word_d = word;
        dst_d = m.rd_addr_in;
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          rd_data_d = mul_res;
          rd_addr_d = dst_q;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (fast || last) begin
          state_d = DONE;
          rd_data_d = div_res;
          rd_addr_d = dst_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (m.flush) begin
      state_d = IDLE;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      op_q <= '0;
      word_q <= 1'b0;
      dst_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      an_q <= an_d;
      bn_q <= bn_d;
      op_q <= op_d;
      word_q <= word_d;
      dst_q <= dst_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign m.in_ready = state_q == IDLE;
  assign m.busy = state_q != IDLE;
  assign m.out_valid = state_q == DONE && !m.flush;
  assign m.rd_addr = rd_addr_q;
  assign m.rd_data = rd_data_q;
endmodule
